// File: rtl/dmem_pkg.sv
// ----------------------------------------------------------------------------
// dmem_pkg
// Shared types and constants for the data-memory latency responder.
//   dmem_state_e     : responder FSM states (DRAIN exists only when
//                      DMEM_POSTED_WRITE_EN is defined)
//   DMEM_LAT_DEFAULT : default access latency in cycles
//   DMEM_AW_DEFAULT  : default word-address width
//   DMEM_CNT_W       : width of the latency counter (covers latencies 1..15)
// Optional feature macro: DMEM_POSTED_WRITE_EN
// ----------------------------------------------------------------------------
package dmem_pkg;

   localparam int DMEM_LAT_DEFAULT = 3;
   localparam int DMEM_AW_DEFAULT  = 6;
   localparam int DMEM_CNT_W       = 4;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      DONE
`ifdef DMEM_POSTED_WRITE_EN
      , DRAIN
`endif
   } dmem_state_e;

endpackage

// File: rtl/dmem_ram.sv
// ----------------------------------------------------------------------------
// dmem_ram
// Single-port synchronous RAM, 2^AW words of 32 bits, registered read.
// Ports:
//   clk   in   clock
//   we    in   write enable (writes wdata to addr at the rising edge)
//   re    in   read enable (captures mem[addr] into the read register)
//   addr  in   word address
//   wdata in   write data
//   rdata out  read register; holds its value while re is low
// No reset port: contents and the read register power up undefined.
// ----------------------------------------------------------------------------
module dmem_ram
   import dmem_pkg::*;
#(
   parameter int AW = DMEM_AW_DEFAULT
) (
   input  logic          clk,
   input  logic          we,
   input  logic          re,
   input  logic [AW-1:0] addr,
   input  logic [31:0]   wdata,
   output logic [31:0]   rdata
);

   logic [31:0] mem [2**AW];
   logic [31:0] rdata_d;
   logic [31:0] rdata_q;

   always_comb begin
      rdata_d = rdata_q;
      if (re) begin
         rdata_d = mem[addr];
      end
   end

   // NOTE: the array has no reset on purpose; a storage array cannot be
   // cleared in one cycle and the block's contract is that reset keeps it.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[addr] <= wdata;
      end
      rdata_q <= rdata_d;
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/dmem_latency_responder.sv
// ----------------------------------------------------------------------------
// dmem_latency_responder
// Memory-side end of the M-stage request/ready handshake. Accepts one load or
// store per transaction, models a fixed LATENCY-cycle access with an FSM and
// down-counter, and returns ready/rdata so the hazard unit can hold M.
// Parameters:
//   LATENCY  cycles from acceptance to the ready pulse (1..15)
//   AW       word-address width; memory holds 2^AW 32-bit words
// Ports:
//   clk        in   rising-edge clock
//   reset      in   asynchronous, active-high
//   mem_write  in   store request (wins if mem_read is also high)
//   mem_read   in   load request
//   addr       in   byte address; bits [AW+1:2] select the word
//   wdata      in   store data
//   rdata      out  load data, registered, held until the next load completes
//   ready      out  access complete, or no access pending
//   busy       out  FSM not in IDLE
// Optional feature macro: DMEM_POSTED_WRITE_EN (one-entry posted write buffer)
// ----------------------------------------------------------------------------
module dmem_latency_responder
   import dmem_pkg::*;
#(
   parameter int LATENCY = DMEM_LAT_DEFAULT,
   parameter int AW      = DMEM_AW_DEFAULT
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        mem_write,
   input  logic        mem_read,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        ready,
   output logic        busy
);

   localparam logic [DMEM_CNT_W-1:0] CNT_INIT = DMEM_CNT_W'(LATENCY - 1);
   localparam logic [DMEM_CNT_W-1:0] CNT_ONE  = DMEM_CNT_W'(1);
   localparam logic [DMEM_CNT_W-1:0] CNT_ZERO = '0;

   dmem_state_e           state_q, state_d;
   logic [DMEM_CNT_W-1:0] cnt_q, cnt_d;
   logic [AW-1:0]         addr_q, addr_d;
   logic [31:0]           wdata_q, wdata_d;
   logic                  is_wr_q, is_wr_d;
   logic                  rdata_vld_q, rdata_vld_d;

   logic                  req;
   logic [AW-1:0]         word_addr;
   logic                  ram_we;
   logic                  ram_re;
   logic [AW-1:0]         ram_addr;
   logic [31:0]           ram_rdata;
   logic                  unused_addr_bits;

   assign req              = mem_write | mem_read;
   assign word_addr        = addr[AW+1:2];
   // Byte offset and high address bits are intentionally dropped (wrap).
   assign unused_addr_bits = ^{addr[31:AW+2], addr[1:0]};

   // NOTE: every output of this block gets a default first, so no path
   // through the case statement can leave a value unassigned (no latches).
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      is_wr_d     = is_wr_q;
      rdata_vld_d = rdata_vld_q;
      ram_we      = 1'b0;
      ram_re      = 1'b0;
      ram_addr    = addr_q;
      ready       = 1'b0;

      unique case (state_q)
         IDLE: begin
            // Non-memory instructions must never stall.
            ready    = !req;
            // With LATENCY==1 the read happens in this acceptance cycle,
            // so the RAM sees the live address rather than the latched one.
            ram_addr = word_addr;
            if (req) begin
               addr_d  = word_addr;
               wdata_d = wdata;
               is_wr_d = mem_write;
               cnt_d   = CNT_INIT;
               state_d = (LATENCY == 1) ? DONE : WAIT;
               ram_re  = (LATENCY == 1) && !mem_write;
`ifdef DMEM_POSTED_WRITE_EN
               // Empty buffer: the store is acknowledged immediately and
               // drains in the background.
               if (mem_write) begin
                  ready   = 1'b1;
                  state_d = DRAIN;
               end
`endif
            end
         end

         WAIT: begin
            cnt_d = cnt_q - CNT_ONE;
            if (cnt_q == CNT_ONE) begin
               state_d = DONE;
               ram_re  = !is_wr_q;
            end
         end

         DONE: begin
            ready   = 1'b1;
            ram_we  = is_wr_q;
            state_d = IDLE;
         end

`ifdef DMEM_POSTED_WRITE_EN
         DRAIN: begin
            // Any new request waits for the buffered store to commit.
            ready = !req;
            if (cnt_q == CNT_ZERO) begin
               ram_we  = 1'b1;
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q - CNT_ONE;
            end
         end
`endif

         default: begin
            state_d = IDLE;
         end
      endcase

      if (ram_re) begin
         rdata_vld_d = 1'b1;
      end
   end

   // NOTE: sequential state uses non-blocking assignments only, so every
   // flop samples the pre-edge values computed above.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         addr_q      <= '0;
         wdata_q     <= '0;
         is_wr_q     <= 1'b0;
         rdata_vld_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         is_wr_q     <= is_wr_d;
         rdata_vld_q <= rdata_vld_d;
      end
   end

   dmem_ram #(
      .AW (AW)
   ) u_ram (
      .clk   (clk),
      .we    (ram_we),
      .re    (ram_re),
      .addr  (ram_addr),
      .wdata (wdata_q),
      .rdata (ram_rdata)
   );

   // The RAM read register has no reset; the valid flag forces rdata to 0
   // from reset until the first load completes.
   assign rdata = ram_rdata & {32{rdata_vld_q}};
   assign busy  = (state_q != IDLE);

endmodule

// File: tb/tb_dmem_latency_responder.sv
// ----------------------------------------------------------------------------
// tb_dmem_latency_responder
// Two responders (LATENCY=3 and LATENCY=1) driven from scoreboard tasks.
// Expected load data is pushed when a load is driven and popped when ready.
// ----------------------------------------------------------------------------
module tb_dmem_latency_responder;

`ifdef DMEM_POSTED_WRITE_EN
   localparam bit POSTED = 1'b1;
`else
   localparam bit POSTED = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic        mem_write_v [2];
   logic        mem_read_v  [2];
   logic [31:0] addr_v      [2];
   logic [31:0] wdata_v     [2];
   logic [31:0] rdata_v     [2];
   logic        ready_v     [2];
   logic        busy_v      [2];

   int          n_vec = 0;
   int          n_err = 0;
   logic [31:0] exp_q [$];
   logic [31:0] mdl [2][64];

   always #5 clk = ~clk;

   dmem_latency_responder #(.LATENCY(3), .AW(6)) u_dut3 (
      .clk       (clk),
      .reset     (reset),
      .mem_write (mem_write_v[0]),
      .mem_read  (mem_read_v[0]),
      .addr      (addr_v[0]),
      .wdata     (wdata_v[0]),
      .rdata     (rdata_v[0]),
      .ready     (ready_v[0]),
      .busy      (busy_v[0])
   );

   dmem_latency_responder #(.LATENCY(1), .AW(6)) u_dut1 (
      .clk       (clk),
      .reset     (reset),
      .mem_write (mem_write_v[1]),
      .mem_read  (mem_read_v[1]),
      .addr      (addr_v[1]),
      .wdata     (wdata_v[1]),
      .rdata     (rdata_v[1]),
      .ready     (ready_v[1]),
      .busy      (busy_v[1])
   );

   function automatic int lat_of(input int s);
      return (s == 0) ? 3 : 1;
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %08h expected %08h", tag, got, exp);
      end
   endtask

   task automatic drive(input int s, input bit wr, input bit rd,
                        input logic [31:0] a, input logic [31:0] d);
      mem_write_v[s] = wr;
      mem_read_v[s]  = rd;
      addr_v[s]      = a;
      wdata_v[s]     = d;
   endtask

   // Called just after a rising edge; counts ready=0 samples until ready=1.
   task automatic wait_ready(input int s, output int zeros, output bit ok);
      zeros = 0;
      ok    = 1'b0;
      for (int i = 0; i < 64; i++) begin
         @(negedge clk);
         if (ready_v[s]) begin
            ok = 1'b1;
            break;
         end
         zeros++;
      end
   endtask

   // One complete transaction on DUT s; starts and ends just after a rising edge.
   // chg: swap the address to a2 (and flip wdata) one cycle after acceptance.
   task automatic access(input string tag, input int s, input bit wr, input bit rd,
                         input logic [31:0] a, input logic [31:0] d,
                         input bit chg, input logic [31:0] a2);
      int          zeros;
      int          z2;
      int          exp_lat;
      bit          ok;
      logic [31:0] exp_data;
      drive(s, wr, rd, a, d);
      if (rd && !wr) exp_q.push_back(mdl[s][a[7:2]]);
      exp_lat = (POSTED && wr) ? 0 : lat_of(s);
      zeros   = 0;
      if (chg) begin
         @(negedge clk);
         if (!ready_v[s]) zeros = 1;
         @(posedge clk); #1;
         addr_v[s]  = a2;
         wdata_v[s] = ~d;
      end
      wait_ready(s, z2, ok);
      zeros += z2;
      check($sformatf("%s done", tag), 32'(ok), 32'd1);
      check($sformatf("%s latency", tag), 32'(zeros), 32'(exp_lat));
      if (rd && !wr) begin
         exp_data = exp_q.pop_front();
         check($sformatf("%s rdata", tag), rdata_v[s], exp_data);
      end
      if (wr) mdl[s][a[7:2]] = d;
      @(posedge clk); #1;
      drive(s, 1'b0, 1'b0, 32'h0, 32'h0);
      for (int i = 0; i < 64; i++) begin
         if (!busy_v[s]) break;
         @(posedge clk); #1;
      end
      @(negedge clk);
      check($sformatf("%s idle ready", tag), 32'(ready_v[s]), 32'd1);
      check($sformatf("%s idle busy", tag), 32'(busy_v[s]), 32'd0);
      @(posedge clk); #1;
   endtask

   initial begin
      int          zeros;
      bit          ok;
      logic [31:0] exp_data;

      reset = 1'b1;
      drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
      drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
      repeat (2) @(posedge clk);
      #1;
      for (int s = 0; s < 2; s++) begin
         check($sformatf("reset ready%0d", s), 32'(ready_v[s]), 32'd1);
         check($sformatf("reset busy%0d", s), 32'(busy_v[s]), 32'd0);
         check($sformatf("reset rdata%0d", s), rdata_v[s], 32'h0);
      end
      reset = 1'b0;
      @(posedge clk); #1;

      // Preload the LATENCY=3 memory through the port.
      access("pre10", 0, 1'b1, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0);
      access("pre04", 0, 1'b1, 1'b0, 32'h04, 32'h11111111, 1'b0, 32'h0);
      access("pre20", 0, 1'b1, 1'b0, 32'h20, 32'h88888888, 1'b0, 32'h0);
      access("pre0c", 0, 1'b1, 1'b0, 32'h0C, 32'h33333333, 1'b0, 32'h0);

      // Plain load, store/load round trip, address change during WAIT.
      access("ld10", 0, 1'b0, 1'b1, 32'h10, 32'h0, 1'b0, 32'h0);
      access("st08", 0, 1'b1, 1'b0, 32'h08, 32'h12345678, 1'b0, 32'h0);
      access("ld08", 0, 1'b0, 1'b1, 32'h08, 32'h0, 1'b0, 32'h0);
      access("ld04chg", 0, 1'b0, 1'b1, 32'h04, 32'h0, 1'b1, 32'h20);

      // Both request lines high is a store.
      access("both", 0, 1'b1, 1'b1, 32'h18, 32'h66666666, 1'b0, 32'h0);
      access("ld18", 0, 1'b0, 1'b1, 32'h18, 32'h0, 1'b0, 32'h0);

      // Byte offset ignored and high address bits wrap.
      access("ld113", 0, 1'b0, 1'b1, 32'h113, 32'h0, 1'b0, 32'h0);
      access("stwrap", 0, 1'b1, 1'b0, 32'hFFFFFFFC, 32'hCAFEF00D, 1'b0, 32'h0);
      access("ld3fc", 0, 1'b0, 1'b1, 32'h3FC, 32'h0, 1'b0, 32'h0);

      // rdata holds across a following store.
      access("st100", 0, 1'b1, 1'b0, 32'h100, 32'h01010101, 1'b0, 32'h0);
      check("rdata hold", rdata_v[0], 32'hCAFEF00D);

      // Reset in the middle of a store: it must not commit.
      drive(0, 1'b1, 1'b0, 32'h0C, 32'hAAAA5555);
      @(negedge clk);
      @(posedge clk); #1;
      drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
      @(negedge clk);
      reset = 1'b1;
      #1;
      check("rst ready", 32'(ready_v[0]), 32'd1);
      check("rst busy", 32'(busy_v[0]), 32'd0);
      check("rst rdata", rdata_v[0], 32'h0);
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      check("post rst ready", 32'(ready_v[0]), 32'd1);
      check("post rst busy", 32'(busy_v[0]), 32'd0);
      @(posedge clk); #1;
      access("ld0c", 0, 1'b0, 1'b1, 32'h0C, 32'h0, 1'b0, 32'h0);

      // LATENCY=1: preload, then back-to-back loads held by the requester.
      access("l1pre00", 1, 1'b1, 1'b0, 32'h00, 32'h00000000, 1'b0, 32'h0);
      access("l1pre04", 1, 1'b1, 1'b0, 32'h04, 32'h0BADF00D, 1'b0, 32'h0);
      drive(1, 1'b0, 1'b1, 32'h00, 32'h0);
      exp_q.push_back(mdl[1][0]);
      @(negedge clk);
      check("b2b ready c0", 32'(ready_v[1]), 32'd0);
      @(posedge clk); #1;
      @(negedge clk);
      check("b2b ready c1", 32'(ready_v[1]), 32'd1);
      exp_data = exp_q.pop_front();
      check("b2b rdata0", rdata_v[1], exp_data);
      @(posedge clk); #1;
      drive(1, 1'b0, 1'b1, 32'h04, 32'h0);
      exp_q.push_back(mdl[1][1]);
      @(negedge clk);
      check("b2b ready c2", 32'(ready_v[1]), 32'd0);
      @(posedge clk); #1;
      @(negedge clk);
      check("b2b ready c3", 32'(ready_v[1]), 32'd1);
      exp_data = exp_q.pop_front();
      check("b2b rdata1", rdata_v[1], exp_data);
      @(posedge clk); #1;
      drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
      @(negedge clk);
      check("b2b idle ready", 32'(ready_v[1]), 32'd1);
      @(posedge clk); #1;

`ifdef DMEM_POSTED_WRITE_EN
      // Posted store acknowledged at once; the following load waits for the
      // drain (LATENCY) and then its own access (LATENCY).
      drive(0, 1'b1, 1'b0, 32'h14, 32'h5A5A1234);
      @(negedge clk);
      check("pw ready c0", 32'(ready_v[0]), 32'd1);
      @(posedge clk); #1;
      mdl[0][5] = 32'h5A5A1234;
      drive(0, 1'b0, 1'b1, 32'h14, 32'h0);
      exp_q.push_back(mdl[0][5]);
      wait_ready(0, zeros, ok);
      check("pw ld done", 32'(ok), 32'd1);
      check("pw ld latency", 32'(zeros), 32'(2 * lat_of(0)));
      exp_data = exp_q.pop_front();
      check("pw ld rdata", rdata_v[0], exp_data);
      @(posedge clk); #1;
      drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
      @(negedge clk);
      check("pw idle busy", 32'(busy_v[0]), 32'd0);
      @(posedge clk); #1;
`else
      zeros = 0;
      ok    = 1'b0;
`endif

      check("scoreboard empty", 32'(exp_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
